// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared widths, state encoding and constants for the instruction loader
package inst_rom_loader_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int DEPTH_LOG2_DEF = 10;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [DATA_W-1:0] NULL_INST = 32'h0;

  // Big-endian placement: byte 0 of a word lands in bits 31:24.
  function automatic logic [DATA_W-1:0] place_byte(input logic [DATA_W-1:0] asm_word,
                                                   input logic [BYTE_W-1:0] b,
                                                   input logic [1:0]        idx);
    logic [DATA_W-1:0] ext;
    ext = {{(DATA_W-BYTE_W){1'b0}}, b};
    return asm_word | (ext << {~idx, 3'b000});
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// rtl/inst_rom_loader_if.sv - fetch and byte-load interfaces between CPU, loader and image source
interface inst_fetch_if;
  import inst_rom_loader_pkg::*;
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] inst;

  modport master (output ce, output addr, input inst);
  modport slave  (input ce, input addr, output inst);
endinterface

interface inst_load_if;
  import inst_rom_loader_pkg::*;
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_last;
  logic              ld_ready;

  modport master (output ld_valid, output ld_byte, output ld_last, input ld_ready);
  modport slave  (input ld_valid, input ld_byte, input ld_last, output ld_ready);
endinterface

// File: rtl/inst_ram.sv
// rtl/inst_ram.sv - word array with one synchronous write port and one combinational read port
module inst_ram
  import inst_rom_loader_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - streams a byte image into instruction RAM, then serves CPU fetches
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_if.slave       fetch,
  inst_load_if.slave        load,
  input  logic              reload,
  output logic              cpu_rst,
  output logic [DEPTH_LOG2:0] ld_words,
  output logic              ld_err
);

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [0:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DEPTH_LOG2:0] words_q, words_d;
  logic                err_q, err_d;
  logic                cpu_rst_q;
  logic                accept, we;
  logic [DATA_W-1:0]   wdata, rdata;
  logic [ADDR_W-1:0]   word_addr;

  assign load.ld_ready = (state_q == ST_LOAD);
  assign accept        = load.ld_ready && load.ld_valid;
  assign wdata         = place_byte(asm_q, load.ld_byte, cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    words_d = words_q;
    err_d   = err_q;
    we      = 1'b0;
    if (reload) begin
      // Restart wins over a byte arriving in the same cycle.
      state_d = ST_LOAD;
      cnt_d   = 2'd0;
      asm_d   = '0;
      words_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (cnt_q == 2'd3 || load.ld_last) begin
        cnt_d = 2'd0;
        asm_d = '0;
        if (words_q == FULL) begin
          err_d = 1'b1;
        end else begin
          we      = 1'b1;
          words_d = words_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = wdata;
      end
      if (load.ld_last) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= 2'd0;
      asm_q     <= '0;
      words_q   <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      words_q   <= words_d;
      err_q     <= err_d;
      cpu_rst_q <= (state_d == ST_LOAD);
    end
  end

  inst_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (words_q[DEPTH_LOG2-1:0]),
    .wdata_i (wdata),
    .raddr_i (word_addr[DEPTH_LOG2-1:0]),
    .rdata_o (rdata)
  );

  // Byte offset bits are dropped; anything above the array depth reads as null.
  assign word_addr  = fetch.addr >> 2;
  assign fetch.inst = (state_q == ST_RUN && fetch.ce &&
                       word_addr[ADDR_W-1:DEPTH_LOG2] == '0) ? rdata : NULL_INST;

  assign cpu_rst  = cpu_rst_q;
  assign ld_words = words_q;
  assign ld_err   = err_q;

endmodule
